// File: rtl/video_in_burst_ctrl.sv
// ---------------------------------------------------------------------------
// video_in_burst_ctrl
//   Drains the video-input pixel FIFO in packs of NB_PACK words and writes
//   them to an external frame buffer as bus write bursts. Addresses advance
//   sequentially through the frame and wrap at FRAME_WORDS. frame_done pulses
//   once per completed frame.
//
// Ports
//   clk, RST            system clock, synchronous active-high reset
//   enable              capture enable, only looked at in IDLE
//   buf_base            frame-buffer byte base, latched at frame start
//   fifo_data           FIFO head word (new head valid 2 cycles after a pop)
//   fifo_pack_avail     FIFO holds at least NB_PACK words
//   fifo_rd             FIFO pop strobe, one pulse per accepted beat
//   wb_cyc/stb/we       bus master controls (we is tied to 1)
//   wb_adr/wb_dat       beat byte address and data
//   wb_ack              beat accepted by the slave
//   busy                burst in progress (START, BEAT, GAP)
//   frame_done          one-cycle pulse after the last word of a frame
//
// Optional build macro VIDEO_IN_BURST_IRQ_EN adds:
//   irq      (out) set on frame_done, held until irq_ack
//   irq_ack  (in)  clears irq, wins over a simultaneous frame_done
//   overrun  (out) sticky, set when a new frame starts with irq pending
// ---------------------------------------------------------------------------
module video_in_burst_ctrl #(
   parameter int DATA_SIZE   = 32,
   parameter int ADDR_W      = 32,
   parameter int NB_PACK     = 16,
   parameter int FRAME_WORDS = 76800
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic                 enable,
   input  logic [ADDR_W-1:0]    buf_base,
   input  logic [DATA_SIZE-1:0] fifo_data,
   input  logic                 fifo_pack_avail,
   output logic                 fifo_rd,
   output logic                 wb_cyc,
   output logic                 wb_stb,
   output logic                 wb_we,
   output logic [ADDR_W-1:0]    wb_adr,
   output logic [DATA_SIZE-1:0] wb_dat,
   input  logic                 wb_ack,
   output logic                 busy,
   output logic                 frame_done
`ifdef VIDEO_IN_BURST_IRQ_EN
   ,
   output logic                 irq,
   input  logic                 irq_ack,
   output logic                 overrun
`endif
);

   localparam int CW = $clog2(FRAME_WORDS + 1);
   localparam int BW = (NB_PACK > 1) ? $clog2(NB_PACK) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BEAT,
      S_GAP,
      S_LAST
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_word_cnt;
   logic [BW-1:0]         r_beat_cnt;
   logic [ADDR_W-1:0]     r_base;
   logic [ADDR_W-1:0]     r_adr;
   logic [DATA_SIZE-1:0]  r_dat;
   logic                  r_live;

   logic                  w_start;
   logic                  w_last_beat;
   logic                  w_frame_end;
   logic [ADDR_W-1:0]     w_base_now;
   logic [ADDR_W-1:0]     w_start_adr;

   assign w_start     = (r_state == S_IDLE) && enable && fifo_pack_avail;
   assign w_last_beat = (r_beat_cnt == BW'(NB_PACK - 1));
   assign w_frame_end = (r_word_cnt == CW'(FRAME_WORDS));
   // At word 0 the base register is being reloaded this very cycle, so the
   // first address of a frame must come straight from buf_base.
   assign w_base_now  = (r_word_cnt == '0) ? buf_base : r_base;
   assign w_start_adr = w_base_now + (ADDR_W'(r_word_cnt) << 2);

   // -------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // -------------------------------------------------------------------
   // FSM next state and bus/FIFO strobes
   // -------------------------------------------------------------------
   always_comb begin
      w_next     = r_state;
      wb_cyc     = 1'b0;
      wb_stb     = 1'b0;
      busy       = 1'b0;
      fifo_rd    = 1'b0;
      frame_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable && fifo_pack_avail) w_next = S_START;
         end
         S_START: begin
            wb_cyc = 1'b1;
            busy   = 1'b1;
            w_next = S_BEAT;
         end
         S_BEAT: begin
            wb_cyc = 1'b1;
            wb_stb = 1'b1;
            busy   = 1'b1;
            if (wb_ack) begin
               // Reset wins even in the ack cycle: no pop may escape.
               fifo_rd = !RST;
               w_next  = w_last_beat ? S_LAST : S_GAP;
            end
         end
         S_GAP: begin
            wb_cyc = 1'b1;
            busy   = 1'b1;
            w_next = S_BEAT;
         end
         S_LAST: begin
            frame_done = w_frame_end && !RST;
            w_next     = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign wb_we  = 1'b1;
   assign wb_adr = r_adr;
   // The FIFO head is only guaranteed valid two cycles after a pop, i.e. in
   // the first BEAT cycle after GAP. In that cycle (and in START) the head is
   // passed straight through and captured; later wait cycles replay it.
   assign wb_dat = r_live ? fifo_data : r_dat;

   // -------------------------------------------------------------------
   // Datapath: counters, base, address and data hold
   // -------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (RST) begin
         r_word_cnt <= '0;
         r_beat_cnt <= '0;
         r_base     <= '0;
         r_adr      <= '0;
         r_dat      <= '0;
         r_live     <= 1'b0;
      end else begin
         r_live <= w_start || (r_state == S_GAP);
         if (r_live) r_dat <= fifo_data;
         case (r_state)
            S_IDLE: begin
               if (r_word_cnt == '0) r_base <= buf_base;
               if (w_start)          r_adr  <= w_start_adr;
            end
            S_START: r_beat_cnt <= '0;
            S_BEAT: begin
               if (wb_ack) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  r_word_cnt <= r_word_cnt + 1'b1;
                  r_adr      <= r_adr + ADDR_W'(4);
               end
            end
            S_LAST: begin
               if (w_frame_end) r_word_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef VIDEO_IN_BURST_IRQ_EN
   logic r_irq;
   logic r_overrun;

   always_ff @(posedge clk) begin
      if (RST) begin
         r_irq     <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (irq_ack)         r_irq <= 1'b0;
         else if (frame_done) r_irq <= 1'b1;
         // Frame start = leaving IDLE at word 0 with capture enabled.
         if (w_start && (r_word_cnt == '0) && r_irq) r_overrun <= 1'b1;
      end
   end

   assign irq     = r_irq;
   assign overrun = r_overrun;
`endif

endmodule

// File: doc/video_in_burst_ctrl.md
Name: video_in_burst_ctrl

Overview:
- Drains the video-input pixel FIFO in packs of NB_PACK words and writes them into an external frame buffer as bus write bursts.
- Sits between the FIFO read side (data_out, r_ack, nb_pack_available) and the system-bus master port.
- Generates sequential frame-buffer addresses, wraps at frame end and signals frame completion.

Parameters:
- DATA_SIZE, 32, FIFO word and bus data width in bits.
- ADDR_W, 32, bus byte-address width.
- NB_PACK, 16, words per burst; must equal the FIFO's NB_PACK.
- FRAME_WORDS, 76800, words per frame (640x480, 4 pixels per word).

Ports:
- clk  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- enable  in  1  capture enable; sampled only in IDLE.
- buf_base  in  ADDR_W  frame-buffer byte base address; latched at frame start.
- fifo_data  in  DATA_SIZE  FIFO head word.
- fifo_pack_avail  in  1  FIFO holds at least NB_PACK words.
- fifo_rd  out  1  FIFO pop strobe (r_ack).
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  beat strobe.
- wb_we  out  1  write enable; constant 1.
- wb_adr  out  ADDR_W  beat byte address.
- wb_dat  out  DATA_SIZE  beat data.
- wb_ack  in  1  beat accepted.
- busy  out  1  burst in progress.
- frame_done  out  1  one-cycle pulse after the last word of a frame is acked.

Behaviour:
- Reset: synchronous, takes priority over all other activity, including mid-burst. State goes to IDLE. fifo_rd, wb_cyc, wb_stb, busy and frame_done go to 0; wb_adr and wb_dat go to 0. The word counter and base register are cleared. The FIFO is not flushed by this block.
- FIFO timing: after a fifo_rd pulse in cycle t, the new head is valid on fifo_data from cycle t+2.
- IDLE:
  - If enable=1 and fifo_pack_avail=1, go to START.
  - At word count 0, latch buf_base into the base register.
- START (1 cycle):
  - wb_cyc=1.
  - wb_adr = base + 4*word_cnt.
  - wb_dat = fifo_data.
  - beat_cnt = 0.
  - Go to BEAT.
- BEAT:
  - wb_cyc=1, wb_stb=1; wb_adr and wb_dat held stable.
  - On wb_ack: pulse fifo_rd for 1 cycle, wb_stb=0, beat_cnt+1, word_cnt+1, wb_adr+4. Go to GAP, or to LAST if beat_cnt was NB_PACK-1.
  - No timeout; the block waits indefinitely for wb_ack.
- GAP (1 cycle):
  - wb_stb=0, wb_cyc=1.
  - Next cycle, wb_dat captures fifo_data and the state goes to BEAT.
  - Minimum beat spacing is 3 cycles (ack cycle, GAP, new beat).
- LAST (1 cycle):
  - wb_cyc=0, busy=0.
  - If word_cnt == FRAME_WORDS: word_cnt=0, pulse frame_done, base re-latched from buf_base in IDLE.
  - Go to IDLE.
- busy = 1 in START, BEAT and GAP.
- Constraints and boundaries:
  - FRAME_WORDS must be a multiple of NB_PACK; a burst never straddles a frame boundary.
  - Address arithmetic is modulo 2^ADDR_W.
  - word_cnt width is ceil(log2(FRAME_WORDS+1)).
  - fifo_pack_avail is not re-checked mid-burst; NB_PACK words are guaranteed by entry condition.
  - enable dropping mid-burst does not abort the burst; the block stops in IDLE afterwards, and word_cnt is retained so capture resumes mid-frame.
  - A buf_base change mid-frame takes effect at the next frame start.
  - wb_ack outside BEAT is ignored.

Optional Feature:
- Macro: VIDEO_IN_BURST_IRQ_EN.
- When defined:
  - Adds ports irq (out, 1) and irq_ack (in, 1).
  - irq is set on frame_done and held until irq_ack=1; irq_ack wins when both occur in the same cycle.
  - Reset value of irq is 0.
  - Also adds output overrun (1). It is a sticky flag set when enable=1, state is IDLE and irq is still pending at a frame start. It is cleared only by RST.
- When undefined: none of these ports or registers exist; frame_done behaviour is unchanged.

Test Plan:
- Reset mid-burst: RST=1 during BEAT, beat 5 -> next cycle state IDLE, wb_cyc=0, fifo_rd=0, no further pops; after release, first burst starts at buf_base.
- Single burst, NB_PACK=16, buf_base=0x1000_0000, wb_ack 1 cycle after each stb -> 16 beats at addresses 0x1000_0000..0x1000_003C, data in FIFO order, exactly 16 fifo_rd pulses, wb_cyc low after the last ack.
- Slow slave, wb_ack after 5 wait cycles per beat -> wb_adr, wb_dat and wb_stb stable throughout the wait; one fifo_rd per ack.
- Frame wrap, FRAME_WORDS=32, buf_base changed to 0x2000_0000 during frame 1 -> frame_done pulses once after word 32; the third burst starts at 0x2000_0000.
- enable dropped during burst 1 with fifo_pack_avail held at 1 -> burst 1 completes all 16 beats, then no new wb_cyc; re-enable resumes at base+64.
- IRQ (VIDEO_IN_BURST_IRQ_EN) -> irq rises the cycle after frame_done and stays high until irq_ack; next frame starting while irq is pending sets overrun=1.
